// File: rtl/net_arq_if.sv
// Bundle of the packet, serial-lane and handshake signals between the upstream
// producer / handshake receiver and the ARQ transmitter.
interface net_arq_if #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned DATA_BITS = 832
) ();
    logic                 send_valid;
    logic [DATA_BITS-1:0] send_data;
    logic                 send_ready;
    logic [NUM_LINES-1:0] serial_out;
    logic                 ack_valid;
    logic                 ack_pid;
    logic                 ack_seq;
    logic                 seq_num;
    logic                 busy;
    logic                 done;
    logic                 fail;

    // Producer / handshake-receiver side.
    modport master (
        output send_valid, send_data, ack_valid, ack_pid, ack_seq,
        input  send_ready, serial_out, seq_num, busy, done, fail
    );

    // Transmitter side.
    modport slave (
        input  send_valid, send_data, ack_valid, ack_pid, ack_seq,
        output send_ready, serial_out, seq_num, busy, done, fail
    );
endinterface

// File: rtl/net_arq_transmitter.sv
// Stop-and-wait ARQ transmitter: stripes one latched packet over NUM_LINES
// serial lanes behind a per-lane syncword and resends on NAK or timeout.
module net_arq_transmitter #(
    parameter int unsigned          NUM_LINES      = 4,
    parameter int unsigned          DATA_BITS      = 832,
    parameter int unsigned          SYNC_BITS      = 8,
    parameter logic [SYNC_BITS-1:0] SYNCWORD       = SYNC_BITS'(8'hFF),
    parameter int unsigned          TIMEOUT_CYCLES = 100,
    parameter int unsigned          MAX_RETRIES    = 3
) (
    input  logic     clk,
    input  logic     rst,
    net_arq_if.slave arq_io
);
    localparam int unsigned LANE_BITS = DATA_BITS / NUM_LINES;
    localparam int unsigned CNT_MAX   = (SYNC_BITS > LANE_BITS) ? SYNC_BITS : LANE_BITS;
    localparam int unsigned BIT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RTY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned SYN_W     = (SYNC_BITS > 1) ? $clog2(SYNC_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_WAIT_ACK
    } state_e;

    state_e               state_q, state_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 seq_q, seq_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [NUM_LINES-1:0] ser_q, ser_d;

    logic                 ack_match_c;
    logic                 resend_c;
    logic [NUM_LINES-1:0] lane_bits_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            data_q  <= '0;
            seq_q   <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            ser_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            seq_q   <= seq_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            ser_q   <= ser_d;
        end
    end

    // Handshakes only count when they carry the sequence bit of the packet in flight.
    assign ack_match_c = arq_io.ack_valid && (arq_io.ack_seq == seq_q);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        data_d   = data_q;
        seq_d    = seq_q;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        resend_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arq_io.send_valid) begin
                    data_d  = arq_io.send_data;
                    retry_d = '0;
                    bit_d   = '0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (bit_q == BIT_W'(SYNC_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_q == BIT_W'(LANE_BITS - 1)) begin
                    timer_d = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ack_match_c && arq_io.ack_pid) begin
                    done_d  = 1'b1;
                    seq_d   = ~seq_q;
                    state_d = ST_IDLE;
                end else if (ack_match_c || (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
                    resend_c = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (resend_c) begin
                    if (retry_q < RTY_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RTY_W'(1);
                        bit_d   = '0;
                        state_d = ST_SYNC;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane i carries slice i MSB first; indexed by the next bit count so the
    // registered lanes line up with the state they belong to.
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_lane
        localparam int unsigned TOP = (l + 1) * LANE_BITS - 1;
        assign lane_bits_c[l] = data_q[IDX_W'(TOP) - IDX_W'(bit_d)];
    end

    always_comb begin
        ser_d = '0;
        case (state_d)
            ST_SYNC: ser_d = {NUM_LINES{SYNCWORD[SYN_W'(SYNC_BITS - 1) - SYN_W'(bit_d)]}};
            ST_DATA: ser_d = lane_bits_c;
            default: ser_d = '0;
        endcase
    end

    assign arq_io.send_ready = (state_q == ST_IDLE);
    assign arq_io.busy       = (state_q != ST_IDLE);
    assign arq_io.serial_out = ser_q;
    assign arq_io.seq_num    = seq_q;
    assign arq_io.done       = done_q;
    assign arq_io.fail       = fail_q;
endmodule
